operand_fwd_ctrl: RTL
=====================

Name: operand_fwd_ctrl

Overview:
- Control stage directly upstream of the EX-stage operand-A/B 3:1 forwarding muxes in the 5-stage RISC-V core.
- Keeps a shadow record of the destination registers in the EX, MEM and WB stages.
- Produces the registered 2-bit mux selects for the instruction entering EX, plus the load-use stall to the IF/ID stages.
- Also keeps a saturating count of stall cycles for performance debug.

Parameters:
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- id_valid  input  1  ID holds a real instruction.
- id_rs1  input  REG_ADDR_W  source 1 index.
- id_rs2  input  REG_ADDR_W  source 2 index.
- id_uses_rs1  input  1  instruction reads rs1.
- id_uses_rs2  input  1  instruction reads rs2.
- id_rd  input  REG_ADDR_W  destination index.
- id_reg_write  input  1  instruction writes rd.
- id_mem_read  input  1  instruction is a load.
- ex_flush  input  1  taken branch/jump resolved in EX; kills the ID instruction.
- pipe_hold  input  1  global freeze (D-cache miss); all state holds.
- fwd_a_sel  output  2  operand-A mux select for the EX instruction.
- fwd_b_sel  output  2  operand-B mux select for the EX instruction.
- stall  output  1  hold PC and IF/ID; EX receives a bubble.
- stall_count  output  CNT_W  saturating count of stall cycles.

Behaviour:
- Select encoding:
  - 2'b00 = register file value.
  - 2'b01 = MEM-stage ALU result.
  - 2'b10 = WB-stage result.
  - 2'b11 is never driven.
- State: three entries ex_q, mem_q, wb_q, each {valid, rd, reg_write, mem_read}.
- Reset (rst_n=0 at posedge): all entries invalid; fwd_a_sel=fwd_b_sel=2'b00; stall_count=0. stall is 0 because ex_q is invalid.
- match(e, rs) = e.valid & e.reg_write & (e.rd==rs) & (rs!=0).
- stall (combinational) = !ex_flush & id_valid & ex_q.mem_read & (match(ex_q,id_rs1)&id_uses_rs1 | match(ex_q,id_rs2)&id_uses_rs2).
- Per-cycle update, if pipe_hold: all entries, selects and counter hold.
- Per-cycle update otherwise:
  - wb_q<=mem_q.
  - mem_q<=ex_q.
  - ex_q<=bubble if (stall | ex_flush | !id_valid), else the ID fields.
- fwd_x_sel is registered on the same edge that loads ex_q (1-cycle latency from ID), computed for rs1 (A) and rs2 (B):
  - 2'b01 if uses & match(ex_q,rs), i.e. the producer moves to MEM.
  - Otherwise 2'b10 if uses & match(mem_q,rs), i.e. the producer moves to WB.
  - Otherwise 2'b00.
  - MEM has priority over WB: the newest producer wins.
- When a bubble is loaded into ex_q, both selects load 2'b00.
- Writes from wb_q to the register file are bypassed inside the register file (write-before-read), so wb_q is never a forwarding source for ID.
- Load-use sequence:
  - Cycle t: stall=1 and a bubble enters EX.
  - Cycle t+1: the load is in mem_q, so the dependent instruction enters EX with select 2'b10.
  - Exactly one stall cycle per load-use pair.
- x0: rs==0 never forwards and never stalls.
- ex_flush with a hazard present: stall=0 (flush wins) and a bubble enters EX.
- stall_count increments on each cycle with stall=1 & !pipe_hold, and saturates at all-ones.
- Reset mid-operation: everything returns to reset values on the next edge. There is no partial state.

Decomposition:
- Shared package core_pkg:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10}.
  - stage_tag_t struct {valid, rd, reg_write, mem_read}.
  - REG_ADDR_W constant.
- Sub-module fwd_match: combinational, one instance per operand; inputs rs, uses, ex_q, mem_q; outputs fwd_sel_t and load_hit.

Test Plan:
- Reset: hold rst_n=0 two cycles with random inputs -> sels=00, stall=0, stall_count=0.
- ALU back-to-back: issue add x5 then sub x6,x5,x1 -> second instruction gets fwd_a_sel=01, fwd_b_sel=00, no stall.
- Distance 2: add x7; nop; or x8,x1,x7 -> fwd_b_sel=10. When x7 is written in both MEM and WB, fwd_b_sel=01 (priority).
- Load-use: lw x9; add x10,x9,x9 -> stall=1 for exactly 1 cycle, bubble in EX, then both sels=10, stall_count=1.
- x0/flush: lw x0 followed by add x1,x0,x0 -> no stall, sels=00. lw x3 with dependent instruction and ex_flush=1 -> stall=0, EX bubble.
- Hold/saturation: pipe_hold=1 for 3 cycles during a load-use -> state and counter frozen. Preload counter near max with CNT_W=4 -> stall_count sticks at 15.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the EX-stage operand forwarding control: mux select
// encoding and the per-stage destination-register shadow tag.
package core_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_tag_t;

  // Producer in stage e writes the register rs reads; x0 never matches.
  function automatic logic tag_match(stage_tag_t e, logic [REG_ADDR_W-1:0] rs);
    return e.valid & e.reg_write & (e.rd == rs) & (rs != '0);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand hazard check: picks the forwarding source for one source
// register and flags a load in EX that this operand depends on.
module fwd_match
  import core_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  uses,
  input  stage_tag_t            ex_q,
  input  stage_tag_t            mem_q,
  output fwd_sel_t              sel,
  output logic                  load_hit
);

  logic ex_hit, mem_hit;

  assign ex_hit   = uses & tag_match(ex_q, rs);
  assign mem_hit  = uses & tag_match(mem_q, rs);
  assign load_hit = ex_hit & ex_q.mem_read;

  // The producer in EX is newer than the one in MEM, so it wins.
  always_comb begin
    sel = FWD_RF;
    if (ex_hit)       sel = FWD_MEM;
    else if (mem_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Forwarding-select and load-use stall control for the EX operand muxes,
// with a saturating stall-cycle counter for performance debug.
module operand_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_flush,
  input  logic                  pipe_hold,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NUM_OPS = 2;

  // WB occupancy is not tracked: the register file's write-before-read
  // bypass covers that stage, so it never affects selects or stall.
  core_pkg::stage_tag_t ex_q, mem_q;

  logic [NUM_OPS-1:0][REG_ADDR_W-1:0] rs;
  logic [NUM_OPS-1:0]                 uses;
  logic [NUM_OPS-1:0]                 load_hit;
  core_pkg::fwd_sel_t                 sel_c [NUM_OPS];
  logic [NUM_OPS-1:0][1:0]            sel_q;
  logic [CNT_W-1:0]                   cnt_q;
  logic                               bubble;

  assign rs   = {id_rs2, id_rs1};
  assign uses = {id_uses_rs2, id_uses_rs1};

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_match u_match (
      .rs       (rs[i]),
      .uses     (uses[i]),
      .ex_q     (ex_q),
      .mem_q    (mem_q),
      .sel      (sel_c[i]),
      .load_hit (load_hit[i])
    );
  end

  // A flush kills the ID instruction, so it can never also be stalled.
  assign stall  = !ex_flush & id_valid & (|load_hit);
  assign bubble = stall | ex_flush | !id_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      sel_q <= '0;
      cnt_q <= '0;
    end else if (!pipe_hold) begin
      mem_q <= ex_q;
      if (bubble) begin
        ex_q  <= '0;
        sel_q <= '0;
      end else begin
        ex_q <= '{valid: 1'b1, rd: id_rd, reg_write: id_reg_write,
                  mem_read: id_mem_read};
        for (int i = 0; i < NUM_OPS; i++) sel_q[i] <= sel_c[i];
      end
      if (stall && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign fwd_a_sel   = sel_q[0];
  assign fwd_b_sel   = sel_q[1];
  assign stall_count = cnt_q;

endmodule
